// File: rtl/m2m_addr_gen.sv
// Address generator for one side of a memory-to-memory transfer: loadable base,
// length, stride, circular mode, abort, and Busy/Last/Done status.
module m2m_addr_gen #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [CNT_W-1:0]  Len,
  input  logic [ADDR_W-1:0] Stride,
  input  logic              Wrap,
  input  logic              Inc,
  input  logic              Abort,
  output logic [ADDR_W-1:0] Addr,
  output logic [CNT_W-1:0]  Count,
  output logic              Busy,
  output logic              Last,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              wrap_q, wrap_d;
  logic              last_s;

  // len_q is never zero while in RUN, so len_q-1 cannot underflow there.
  assign last_s = (state_q == S_RUN) && (cnt_q == (len_q - CNT_ONE));

  // Next-state and datapath update; Abort takes priority over Inc in RUN.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    len_d    = len_q;
    stride_d = stride_q;
    wrap_d   = wrap_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Len != CNT_ZERO) begin
            base_d   = BaseAddr;
            len_d    = Len;
            stride_d = Stride;
            wrap_d   = Wrap;
            addr_d   = BaseAddr;
            cnt_d    = CNT_ZERO;
            state_d  = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (Inc) begin
          if (!last_s) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q + CNT_ONE;
          end else if (wrap_q) begin
            addr_d = base_q;
            cnt_d  = CNT_ZERO;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      addr_q   <= ADDR_ZERO;
      cnt_q    <= CNT_ZERO;
      base_q   <= ADDR_ZERO;
      len_q    <= CNT_ZERO;
      stride_q <= ADDR_ZERO;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Addr  = addr_q;
  assign Count = cnt_q;
  assign Busy  = (state_q == S_RUN);
  assign Done  = (state_q == S_DONE);
  assign Last  = last_s;

endmodule

// File: tb/tb_m2m_addr_gen.sv
// Directed bench for m2m_addr_gen with hand-computed expected outputs.
module tb_m2m_addr_gen;

  logic       clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] BaseAddr;
  logic [3:0] Len;
  logic [2:0] Stride;
  logic       Wrap;
  logic       Inc;
  logic       Abort;
  logic [2:0] Addr;
  logic [3:0] Count;
  logic       Busy;
  logic       Last;
  logic       Done;

  int vectors = 0;
  int miscompares = 0;

  m2m_addr_gen #(.ADDR_W(3), .CNT_W(4)) dut (
    .clock(clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
    .Len(Len), .Stride(Stride), .Wrap(Wrap), .Inc(Inc), .Abort(Abort),
    .Addr(Addr), .Count(Count), .Busy(Busy), .Last(Last), .Done(Done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] a, input logic [3:0] c,
                            input logic b, input logic l, input logic d);
    vectors++;
    assert ({Addr, Count, Busy, Last, Done} === {a, c, b, l, d}) else begin
      miscompares++;
      $error("FAIL %s: observed addr=%0d cnt=%0d busy=%0b last=%0b done=%0b, expected addr=%0d cnt=%0d busy=%0b last=%0b done=%0b",
             tag, Addr, Count, Busy, Last, Done, a, c, b, l, d);
    end
  endtask

  task automatic start(input logic [2:0] b, input logic [3:0] n, input logic [2:0] s, input logic w);
    Start = 1'b1; BaseAddr = b; Len = n; Stride = s; Wrap = w;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; BaseAddr = 3'd0; Len = 4'd0; Stride = 3'd0;
    Wrap = 1'b0; Inc = 1'b0; Abort = 1'b0;
    tick();
    tick();
    expect_out("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    expect_out("idle_after_reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Basic run: base 2, len 4, stride 1, Inc held high
    Inc = 1'b1;
    start(3'd2, 4'd4, 3'd1, 1'b0);
    expect_out("basic_a2", 3'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("basic_a3", 3'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("basic_a4", 3'd4, 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("basic_a5_last", 3'd5, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("basic_done", 3'd5, 4'd3, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("basic_idle", 3'd5, 4'd3, 1'b0, 1'b0, 1'b0);

    // Address overflow: 6,7,0,1
    start(3'd6, 4'd4, 3'd1, 1'b0);
    expect_out("wrap_a6", 3'd6, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("wrap_a7", 3'd7, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("wrap_a0", 3'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("wrap_a1_last", 3'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("wrap_done", 3'd1, 4'd3, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("wrap_idle", 3'd1, 4'd3, 1'b0, 1'b0, 1'b0);

    // Second transfer: base 3, len 2, stride 3 -> 3,6
    start(3'd3, 4'd2, 3'd3, 1'b0);
    expect_out("s3_a3", 3'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("s3_a6_last", 3'd6, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("s3_done", 3'd6, 4'd1, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("s3_idle", 3'd6, 4'd1, 1'b0, 1'b0, 1'b0);

    // Inc gaps: pattern 1,0,0,1,1 -> 0,1,1,1,2 then Done
    Inc = 1'b0;
    start(3'd0, 4'd3, 3'd1, 1'b0);
    expect_out("gap_a0", 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    Inc = 1'b1; tick(); expect_out("gap_a1", 3'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    Inc = 1'b0; tick(); expect_out("gap_hold1", 3'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("gap_hold2", 3'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    Inc = 1'b1; tick(); expect_out("gap_a2_last", 3'd2, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("gap_done", 3'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("gap_idle", 3'd2, 4'd2, 1'b0, 1'b0, 1'b0);

    // Circular mode: 1,3,5,1,3,5,1,3 then abort at Addr=3
    start(3'd1, 4'd3, 3'd2, 1'b1);
    expect_out("circ_1a", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("circ_3a", 3'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("circ_5a", 3'd5, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("circ_1b", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("circ_3b", 3'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("circ_5b", 3'd5, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("circ_1c", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("circ_3c", 3'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    Abort = 1'b1;
    tick(); expect_out("abort_idle", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    Abort = 1'b0;
    tick(); expect_out("abort_no_done", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);

    // Empty transfer: Done one cycle after Start, Addr unchanged, never Busy
    start(3'd5, 4'd0, 3'd1, 1'b0);
    expect_out("empty_done", 3'd3, 4'd1, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("empty_idle", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);

    // Start and config changes mid-run are ignored
    start(3'd0, 4'd4, 3'd1, 1'b0);
    expect_out("mid_a0", 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    Start = 1'b1; BaseAddr = 3'd7; Len = 4'd2; Stride = 3'd3; Wrap = 1'b1;
    tick(); expect_out("mid_a1", 3'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("mid_a2", 3'd2, 4'd2, 1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    tick(); expect_out("mid_a3_last", 3'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("mid_done", 3'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    Start = 1'b1; BaseAddr = 3'd6; Len = 4'd2;
    tick(); expect_out("start_in_done_ignored", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0);
    Start = 1'b0;
    tick(); expect_out("still_idle", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    start(3'd4, 4'd5, 3'd1, 1'b0);
    expect_out("ar_a4", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ar_a5", 3'd5, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("ar_a6", 3'd6, 4'd2, 1'b1, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1 expect_out("ar_immediate", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("ar_held", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    start(3'd1, 4'd2, 3'd1, 1'b0);
    expect_out("post_a1", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("post_a2_last", 3'd2, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("post_done", 3'd2, 4'd1, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("post_idle", 3'd2, 4'd1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m2m_addr_gen.md
Name: m2m_addr_gen

Overview:
Parametrised address generator for the memory-to-memory transfer datapath. It replaces the fixed 3-bit increment-only address counters. It adds a loadable base address, programmable length and stride, a circular (wrap) mode, abort, and Busy/Last/Done status. One instance drives the source memory and one drives the destination memory; the transfer controller steps each instance with Inc.

Parameters:
ADDR_W, 3, address width in bits; address arithmetic is modulo 2^ADDR_W
CNT_W, 4, width of length and beat counter; max transfer length is 2^CNT_W-1

Ports:
clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin transfer; sampled only in IDLE
BaseAddr  in  ADDR_W  first address of transfer
Len  in  CNT_W  number of addresses to issue; 0 = empty transfer
Stride  in  ADDR_W  address increment per beat
Wrap  in  1  1 = circular mode: restart at base after last beat, never finishes
Inc  in  1  advance to next address; honoured only in RUN
Abort  in  1  terminate transfer immediately; honoured only in RUN
Addr  out  ADDR_W  current address (registered)
Count  out  CNT_W  beats completed in current pass (registered)
Busy  out  1  high while in RUN
Last  out  1  Busy and Count == Len_q-1; current Addr is the final beat of the pass
Done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset is asynchronous and active-high. On Reset, state = IDLE; Addr=0, Count=0, Busy=0, Last=0, Done=0. These take effect immediately, not at the next edge, including mid-transfer.
- States: IDLE, RUN, DONE. Busy = (state==RUN). Done = (state==DONE). Both are decoded from the state register, so there is no combinational path from inputs to outputs. Last is combinational from registers only.
- IDLE, Start=1, Len!=0:
  - latch BaseAddr, Len, Stride, Wrap into base_q, len_q, stride_q, wrap_q
  - Addr<=BaseAddr, Count<=0, go to RUN
  - BaseAddr is presented on Addr the cycle after Start
- IDLE, Start=1, Len==0: go to DONE. Addr and Count are unchanged; Busy never asserts.
- IDLE, Start=0: hold all state.
- RUN, priority Abort > Inc:
  - Abort=1: go to IDLE. Addr and Count hold; no Done pulse.
  - Inc=1, not Last: Addr<=(Addr+stride_q) mod 2^ADDR_W, Count<=Count+1.
  - Inc=1, Last, wrap_q=1: Addr<=base_q, Count<=0, stay in RUN.
  - Inc=1, Last, wrap_q=0: go to DONE. Addr and Count hold their final values.
  - Inc=0: hold.
- DONE: lasts exactly one cycle, then goes to IDLE. Start during DONE is ignored.
- Start in RUN or DONE is ignored. Changes on BaseAddr, Len, Stride and Wrap after the Start cycle have no effect on the transfer.
- Stride=0 is legal: Addr stays constant while Count advances. Address overflow wraps silently.
- Latency from an Inc edge to the new Addr is 1 cycle. Done rises 1 cycle after the edge that accepts the last Inc.

Test Plan:
- Reset, then Start with BaseAddr=2, Len=4, Stride=1, Wrap=0, Inc held high.
  - Addr=2,3,4,5 on successive cycles; Last high only while Addr=5.
  - Busy falls and Done=1 for exactly one cycle; next cycle Done=0 and Addr stays 5.
- Address wrap: BaseAddr=6, Len=4, Stride=1, Inc high.
  - Addr=6,7,0,1, then Done pulse.
  - A second Start with BaseAddr=3, Len=2, Stride=3 yields Addr=3,6.
- Inc gaps: BaseAddr=0, Len=3, Stride=1, Inc pattern 1,0,0,1,1.
  - Addr=0,1,1,1,2, then Done.
  - Count holds during the gaps; Last is high while Addr=2.
- Circular mode and abort: BaseAddr=1, Len=3, Stride=2, Wrap=1, Inc high.
  - Addr=1,3,5,1,3,5,1 with no Done.
  - Abort while Addr=3: Busy=0 next cycle, Addr stays 3, Done never pulses.
- Empty transfer and Start filtering:
  - Start with Len=0: Done pulses one cycle after Start; Busy stays 0; Addr unchanged.
  - Start asserted mid-RUN does not restart the address sequence.
- Async reset mid-run: BaseAddr=4, Len=5, stepping.
  - Assert Reset between clock edges: Addr=0, Count=0, Busy=0 immediately, before the next edge.
  - After release, Start with BaseAddr=1 runs normally.
